grey_ptr_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences write/read pointers for an external dual-port RAM.
- Pointers are kept in binary and exported as Grey-coded values (bin ^ (bin >> 1)), so a later CDC stage can synchronise them without change.
- Generates RAM addresses, full/empty flags, an occupancy count, and error pulses on rejected accesses.
- Sits between producer/consumer handshakes and the storage array.

---
 rtl/grey_ptr_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_grey_ptr_fifo_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/grey_ptr_fifo_ctrl.sv
// Single-clock FIFO pointer controller with binary pointers exported as Grey code.
// Optional almost_full/almost_empty flags are built when ALMOST_FLAGS_EN is defined.
module grey_ptr_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH:0]   wr_ptr_grey,
    output logic [ADDR_WIDTH:0]   rd_ptr_grey,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`ifdef ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam int PW = ADDR_WIDTH + 1;
    // Inverting the two MSBs of a Grey pointer gives the value it takes one lap later.
    localparam logic [PW-1:0] LAP_MASK = PW'(3) << (PW - 2);

    function automatic logic [PW-1:0] bin2grey(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0] wr_bin, rd_bin;
    logic [PW-1:0] wr_bin_nx, rd_bin_nx;
    logic [PW-1:0] wr_grey_nx, rd_grey_nx;
    logic [PW-1:0] count_nx;

    assign ram_we  = wr_en && !full;
    assign ram_re  = rd_en && !empty;
    assign wr_addr = wr_bin[ADDR_WIDTH-1:0];
    assign rd_addr = rd_bin[ADDR_WIDTH-1:0];

    always_comb begin
        wr_bin_nx  = wr_bin + PW'(ram_we);
        rd_bin_nx  = rd_bin + PW'(ram_re);
        wr_grey_nx = bin2grey(wr_bin_nx);
        rd_grey_nx = bin2grey(rd_bin_nx);
        count_nx   = wr_bin_nx - rd_bin_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bin      <= '0;
            rd_bin      <= '0;
            wr_ptr_grey <= '0;
            rd_ptr_grey <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wr_bin      <= wr_bin_nx;
            rd_bin      <= rd_bin_nx;
            wr_ptr_grey <= wr_grey_nx;
            rd_ptr_grey <= rd_grey_nx;
            count       <= count_nx;
            full        <= (wr_grey_nx == (rd_grey_nx ^ LAP_MASK));
            empty       <= (wr_grey_nx == rd_grey_nx);
            overflow    <= wr_en && full;
            underflow   <= rd_en && empty;
        end
    end

`ifdef ALMOST_FLAGS_EN
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    generate
        if (AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_levels
            $error("grey_ptr_fifo_ctrl: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nx >= AF_L);
            almost_empty <= (count_nx <= AE_L);
        end
    end
`else
    logic unused_levels;
    assign unused_levels = ^{AF_LEVEL, AE_LEVEL};
`endif

endmodule

// File: tb/tb_grey_ptr_fifo_ctrl.sv
// Scoreboard bench for grey_ptr_fifo_ctrl: an occupancy/transfer-count model predicts
// every cycle's outputs, and a negedge monitor pops and compares them.
module tb_grey_ptr_fifo_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst, wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic ram_we, ram_re, full, empty, overflow, underflow;
    logic [AW:0] wr_ptr_grey, rd_ptr_grey, count;
`ifdef ALMOST_FLAGS_EN
    logic almost_full, almost_empty;
`endif

    grey_ptr_fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .ram_we(ram_we), .ram_re(ram_re),
        .wr_ptr_grey(wr_ptr_grey), .rd_ptr_grey(rd_ptr_grey),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
`ifdef ALMOST_FLAGS_EN
        , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int cnt;
        bit ovf, unf, we, re, af, ae;
        int wg, rg, wa, ra;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: occupancy plus total accepted writes/reads since reset.
    int m_occ, m_wtot, m_rtot;
    bit m_ovf, m_unf;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    // Called at posedge+1: drive inputs, log expectations for this cycle, advance model.
    task automatic step(input bit w, input bit r, input bit rs);
        exp_t e;
        bit wacc, racc;
        wr_en = w; rd_en = r; rst = rs;
        wacc = w && (m_occ < DEPTH);
        racc = r && (m_occ > 0);
        e.due = cyc;       e.cnt = m_occ;
        e.ovf = m_ovf;     e.unf = m_unf;
        e.we  = wacc;      e.re  = racc;
        e.wg  = gray(m_wtot % 32); e.rg = gray(m_rtot % 32);
        e.wa  = m_wtot % 16;       e.ra = m_rtot % 16;
        e.af  = (m_occ >= 12);     e.ae = (m_occ <= 2);
        sb.push_back(e);
        if (rs) begin
            m_occ = 0; m_wtot = 0; m_rtot = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_ovf  = w && (m_occ == DEPTH);
            m_unf  = r && (m_occ == 0);
            m_occ  = m_occ + int'(wacc) - int'(racc);
            m_wtot = (m_wtot + int'(wacc)) % 64;
            m_rtot = (m_rtot + int'(racc)) % 64;
        end
        @(posedge clk); #1;
    endtask

    logic [AW:0] prev_wg, prev_rg;
    bit          have_prev = 0;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("scoreboard_slot", e.due, cyc);
            chk("count", int'(count), e.cnt);
            chk("full", int'(full), int'(e.cnt == DEPTH));
            chk("empty", int'(empty), int'(e.cnt == 0));
            chk("overflow", int'(overflow), int'(e.ovf));
            chk("underflow", int'(underflow), int'(e.unf));
            chk("wr_ptr_grey", int'(wr_ptr_grey), e.wg);
            chk("rd_ptr_grey", int'(rd_ptr_grey), e.rg);
            chk("ram_we", int'(ram_we), int'(e.we));
            chk("ram_re", int'(ram_re), int'(e.re));
            chk("wr_addr", int'(wr_addr), e.wa);
            chk("rd_addr", int'(rd_addr), e.ra);
`ifdef ALMOST_FLAGS_EN
            chk("almost_full", int'(almost_full), int'(e.af));
            chk("almost_empty", int'(almost_empty), int'(e.ae));
`endif
            // Flag/count consistency, independent of the model.
            chk("full_vs_count", int'(full), int'(count == 5'(DEPTH)));
            chk("empty_vs_count", int'(empty), int'(count == 0));
            if (have_prev && wr_ptr_grey != prev_wg && wr_ptr_grey != 0)
                chk("wr_grey_hamming", $countones(wr_ptr_grey ^ prev_wg), 1);
            if (have_prev && rd_ptr_grey != prev_rg && rd_ptr_grey != 0)
                chk("rd_grey_hamming", $countones(rd_ptr_grey ^ prev_rg), 1);
            prev_wg   = wr_ptr_grey;
            prev_rg   = rd_ptr_grey;
            have_prev = 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        m_occ = 0; m_wtot = 0; m_rtot = 0; m_ovf = 0; m_unf = 0;
        @(posedge clk); #1;
        step(0, 0, 1);
        repeat (4) step(0, 0, 0);               // idle after reset
        repeat (16) step(1, 0, 0);              // fill to full
        repeat (3) step(1, 0, 0);               // overflow while full
        step(1, 1, 0);                          // full + both: read only
        repeat (15) step(0, 1, 0);              // drain
        step(1, 1, 0);                          // empty + both: write only
        step(0, 1, 0);
        for (int i = 0; i < 40; i++) begin      // interleave across pointer wrap
            step(1, 0, 0);
            step(0, 1, 0);
        end
        repeat (2) step(0, 0, 0);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 0);
        while (m_occ > 0) step(0, 1, 0);
        repeat (7) step(1, 0, 0);               // count reaches 7
        step(1, 0, 1);                          // reset mid-stream, wr_en high
        repeat (3) step(0, 0, 0);
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 40),
                 1'($urandom_range(0, 99) < 2));
        step(0, 0, 0);
        @(negedge clk); #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
